// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning block: debounce FSM
// state encoding and the default acceptance window.
package btn_pkg;

    // Two-bit debounce FSM encoding; every code is legal but the FSM still
    // recovers to StIdle through its default branch.
    typedef enum logic [1:0] {
        StIdle       = 2'b00,
        StDebPress   = 2'b01,
        StPressed    = 2'b10,
        StDebRelease = 2'b11
    } btn_state_e;

    // 100 ms at 50 MHz.
    localparam int unsigned DefaultStableCount = 5000000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for slow asynchronous inputs.
// The reset value lets the chain start at the idle level of the pin so that
// reset exit never looks like an input transition.
module sync_2ff #(
    parameter int unsigned         WIDTH       = 1,
    parameter logic [WIDTH-1:0]    RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button front end: synchronises the raw pin, normalises polarity so that
// 1 means pressed, rejects bounce shorter than STABLE_COUNT cycles and emits a
// clean level plus single-cycle press/release strobes.
// Optional build macro HOLD_REPEAT_EN adds auto-repeat press strobes while the
// button stays held (REPEAT_DELAY to the first, then every REPEAT_PERIOD).
module button_debouncer
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_COUNT  = DefaultStableCount,
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned   CntW    = $clog2(STABLE_COUNT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_COUNT - 1);

    // Reject configurations the counters cannot represent.
    if (STABLE_COUNT < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("button_debouncer: STABLE_COUNT, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic       btn_synced;
    logic       btn_sync;

    btn_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       press_q, press_d;
    logic       release_q, release_d;

    // Synchroniser resets to the released pin level, so btn_sync starts at 0.
    sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (ACTIVE_LOW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (btn_synced)
    );

    assign btn_sync = btn_synced ^ ACTIVE_LOW;

`ifdef HOLD_REPEAT_EN
    localparam int unsigned HoldMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned HoldW   = $clog2(HoldMax + 1);
    localparam logic [HoldW-1:0] DelayLast  = HoldW'(REPEAT_DELAY - 1);
    localparam logic [HoldW-1:0] PeriodLast = HoldW'(REPEAT_PERIOD - 1);

    logic [HoldW-1:0] hold_q, hold_d;
    logic             rep_q, rep_d;   // first repeat already issued: use the period
    logic             repeat_fire;

    // Hold counter: runs only while settled in StPressed with the button down.
    always_comb begin
        hold_d      = hold_q;
        rep_d       = rep_q;
        repeat_fire = 1'b0;
        if (state_q == StPressed && btn_sync) begin
            if (hold_q == (rep_q ? PeriodLast : DelayLast)) begin
                repeat_fire = 1'b1;
                hold_d      = '0;
                rep_d       = 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end else begin
            hold_d = '0;
            rep_d  = 1'b0;
        end
    end

    // Hold counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            rep_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end
`endif

    // Debounce FSM next state, window counter and pulse requests.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (btn_sync) begin
                    state_d = StDebPress;
                    cnt_d   = '0;
                end
            end
            StDebPress: begin
                if (!btn_sync) begin
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    state_d = StPressed;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPressed: begin
                if (!btn_sync) begin
                    state_d = StDebRelease;
                    cnt_d   = '0;
                end
            end
            StDebRelease: begin
                if (btn_sync) begin
                    state_d = StPressed;
                end else if (cnt_q == CntLast) begin
                    state_d   = StIdle;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase

`ifdef HOLD_REPEAT_EN
        press_d = press_d | repeat_fire;
`endif
    end

    // FSM, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (STABLE_COUNT=4, active-low pin,
// REPEAT_DELAY=10, REPEAT_PERIOD=3). Directed scenarios followed by random
// bursts, every cycle compared against a run-length reference model.
module tb_button_debouncer;

    localparam int unsigned S  = 4;
    localparam bit          AL = 1'b1;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 3;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    // Reference model: 2-edge pipeline, then a mismatch run length.
    bit m_s1, m_s2, m_level, m_press, m_rel;
    int m_run, m_held;

    always #5 clk = ~clk;

    button_debouncer #(
        .STABLE_COUNT  (S),
        .ACTIVE_LOW    (AL),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    function automatic void model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0;
        m_press = 1'b0; m_rel = 1'b0;
        m_run = 0; m_held = 0;
    endfunction

    // A new level is accepted once the synced value has differed from the
    // accepted level on S+1 consecutive edges.
    function automatic void model_edge(input logic raw);
        bit sync;
        bit lvl_b;
        int run_b;
        sync  = m_s2;
        m_s2  = m_s1;
        m_s1  = raw ^ AL;
        lvl_b = m_level;
        run_b = m_run;
        m_press = 1'b0;
        m_rel   = 1'b0;
        if (sync != m_level) begin
            m_run++;
            if (m_run == int'(S) + 1) begin
                m_level = sync;
                m_run   = 0;
                if (sync) m_press = 1'b1;
                else      m_rel   = 1'b1;
            end
        end else begin
            m_run = 0;
        end
`ifdef HOLD_REPEAT_EN
        if (lvl_b && run_b == 0 && sync) begin
            m_held++;
            if (m_held == int'(RD) || (m_held > int'(RD) && (m_held - int'(RD)) % int'(RP) == 0))
                m_press = 1'b1;
        end else begin
            m_held = 0;
        end
`else
        if (lvl_b && run_b == 0) m_held = 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "/level"},   btn_level,     m_level);
        chk({tag, "/press"},   press_pulse,   m_press);
        chk({tag, "/release"}, release_pulse, m_rel);
        chk({tag, "/exclusive"}, press_pulse & release_pulse, 1'b0);
    endtask

    // Drive the pin for one clock, then update the model and compare.
    task automatic cyc(input logic raw, input string tag);
        btn_raw = raw;
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else     model_edge(raw);
        check_model(tag);
    endtask

    // Asynchronous reset asserted between edges, held for n edges.
    task automatic pulse_reset(input int n, input logic raw, input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        chk({tag, "/async_level"}, btn_level, 1'b0);
        chk({tag, "/async_press"}, press_pulse, 1'b0);
        chk({tag, "/async_release"}, release_pulse, 1'b0);
        for (int i = 0; i < n; i++) cyc(raw, tag);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = 1'b1;
        model_reset();

        // Reset state with the pin released.
        for (int i = 0; i < 3; i++) cyc(1'b1, "reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, "idle");

        // 1. Clean press: pulse on edge 7 after the pin falls.
        for (int k = 1; k <= 7; k++) begin
            cyc(1'b0, "t1");
            chk("t1_press_edge", press_pulse, k == 7);
            chk("t1_level", btn_level, k >= 7);
        end

        // 5. Hold for 30 cycles after acceptance.
        for (int k = 1; k <= 30; k++) begin
            cyc(1'b0, "t5");
`ifdef HOLD_REPEAT_EN
            chk("t5_repeat", press_pulse, k >= int'(RD) && (k - int'(RD)) % int'(RP) == 0);
`else
            chk("t5_no_repeat", press_pulse, 1'b0);
`endif
            chk("t5_level_held", btn_level, 1'b1);
        end

        // 3. Release: release pulse on edge 7.
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, "t3");
            chk("t3_release_edge", release_pulse, k == 7);
            chk("t3_level", btn_level, k < 7);
        end
        for (int i = 0; i < 3; i++) cyc(1'b1, "idle");

        // 2. Bounce: low 3, high 2, then low held.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, "t2_burst");
            chk("t2_burst_press", press_pulse, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, "t2_burst");
            chk("t2_burst_press", press_pulse, 1'b0);
        end
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, "t2");
            chk("t2_press_edge", press_pulse, k == 7);
        end
        for (int i = 0; i < 10; i++) cyc(1'b1, "t2_release");

        // 4. Reset two cycles into the press window, button still held.
        for (int i = 0; i < 5; i++) cyc(1'b0, "t4_pre");
        pulse_reset(2, 1'b0, "t4_rst");
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, "t4");
            chk("t4_press_edge", press_pulse, k == 7);
            chk("t4_release", release_pulse, 1'b0);
        end

        // Random bursts with occasional long holds and resets.
        for (int b = 0; b < 80; b++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(12, 30))
                                              : int'($urandom_range(1, 9));
            if ($urandom_range(0, 19) == 0) pulse_reset(int'($urandom_range(1, 2)), lvl, "rnd_rst");
            for (int i = 0; i < len; i++) cyc(lvl, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
